vm_change_dispenser: RTL and testbench

//  Actuator-side consumer of the vending FSM outputs. Samples {purchase, cash_ret} every clock,

---
 rtl/vm_pkg.sv | 38 +++
 rtl/vm_change_dispenser_if.sv | 31 +++
 rtl/vm_req_fifo.sv | 58 +++++
 rtl/vm_change_dispenser.sv | 142 ++++++++++++++
 tb/tb_vm_change_dispenser.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending actuator slice: change codes, coin-in codes,
// request-word layout and the dispenser handshake FSM encoding.
package vm_pkg;

  localparam logic [1:0] RET_0TK  = 2'b00;
  localparam logic [1:0] RET_5TK  = 2'b01;
  localparam logic [1:0] RET_10TK = 2'b10;
  localparam logic [1:0] RET_15TK = 2'b11;

  localparam logic [1:0] CASH_NONE = 2'b00;
  localparam logic [1:0] CASH_5TK  = 2'b01;
  localparam logic [1:0] CASH_10TK = 2'b10;

  // Request word is {purchase, cash_ret}; one bit per pending mechanism action.
  localparam int WORD_W   = 3;
  localparam int BIT_VEND = 2;
  localparam int BIT_C10  = 1;
  localparam int BIT_C5   = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_VEND    = 3'd2,
    S_COIN10  = 3'd3,
    S_COIN5   = 3'd4,
    S_ACK_LOW = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  // Service order is product first, then the 10tk coin, then the 5tk coin.
  function automatic state_e next_item(input logic [WORD_W-1:0] w);
    if (w[BIT_VEND]) return S_VEND;
    if (w[BIT_C10])  return S_COIN10;
    if (w[BIT_C5])   return S_COIN5;
    return S_IDLE;
  endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Signal bundle between the vending FSM / mechanism drivers (master) and the
// change dispenser (slave).
interface vm_change_dispenser_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             purchase;
  logic [1:0]       cash_ret;
  logic             vend_req;
  logic             vend_ack;
  logic             coin5_req;
  logic             coin10_req;
  logic             coin_ack;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             fault;
  logic             clr_fault;

  modport master (
    output purchase, cash_ret, vend_ack, coin_ack, clr_fault,
    input  vend_req, coin5_req, coin10_req, busy, fifo_level, overflow, fault
  );

  modport slave (
    input  purchase, cash_ret, vend_ack, coin_ack, clr_fault,
    output vend_req, coin5_req, coin10_req, busy, fifo_level, overflow, fault
  );

endinterface

// File: rtl/vm_req_fifo.sv
// Small synchronous request queue; storage is not reset, only the pointers and level.
module vm_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WORD_W-1:0]          push_data,
  input  logic                       pop,
  output logic [WORD_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/vm_change_dispenser.sv
// Queues {purchase, cash_ret} requests and plays them out to the product and coin
// mechanisms over four-phase req/ack handshakes, with a per-wait timeout.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  vm_change_dispenser_if.slave  bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [WORD_W-1:0] cap_word;
  logic              cap_valid;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [WORD_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] work_q, work_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              ack_sel_q, ack_sel_d;
  logic              in_wait, enter_fault;
  logic              overflow_q, overflow_d;
  logic              fault_q, fault_d;
  logic              vend_req_q, vend_req_d;
  logic              coin10_req_q, coin10_req_d;
  logic              coin5_req_q, coin5_req_d;

  assign cap_word  = {bus.purchase, bus.cash_ret};
  assign cap_valid = |cap_word;
  assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign fifo_push = cap_valid && (!fifo_full || fifo_pop);
  assign drop      = cap_valid && fifo_full && !fifo_pop;

  vm_req_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cap_word),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign in_wait = (state_q inside {S_VEND, S_COIN10, S_COIN5, S_ACK_LOW});

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    ack_sel_d   = ack_sel_q;
    tmo_d       = '0;
    enter_fault = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) begin
        work_d  = fifo_head;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = next_item(work_q);
      S_VEND: if (bus.vend_ack) begin
        work_d[BIT_VEND] = 1'b0;
        ack_sel_d        = 1'b0;
        state_d          = S_ACK_LOW;
      end
      S_COIN10: if (bus.coin_ack) begin
        work_d[BIT_C10] = 1'b0;
        ack_sel_d       = 1'b1;
        state_d         = S_ACK_LOW;
      end
      S_COIN5: if (bus.coin_ack) begin
        work_d[BIT_C5] = 1'b0;
        ack_sel_d      = 1'b1;
        state_d        = S_ACK_LOW;
      end
      // ack_sel_q remembers which acknowledge must return low before moving on.
      S_ACK_LOW: if (!(ack_sel_q ? bus.coin_ack : bus.vend_ack)) state_d = next_item(work_q);
      S_FAULT:   if (bus.clr_fault) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (in_wait && (state_d == state_q)) begin
      if (tmo_q == TMO_LAST) begin
        state_d     = S_FAULT;
        work_d      = '0;
        enter_fault = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_comb begin
    overflow_d   = (overflow_q && !bus.clr_fault) || drop;
    fault_d      = (fault_q && !bus.clr_fault) || enter_fault;
    vend_req_d   = (state_d == S_VEND);
    coin10_req_d = (state_d == S_COIN10);
    coin5_req_d  = (state_d == S_COIN5);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      work_q       <= '0;
      tmo_q        <= '0;
      ack_sel_q    <= 1'b0;
      overflow_q   <= 1'b0;
      fault_q      <= 1'b0;
      vend_req_q   <= 1'b0;
      coin10_req_q <= 1'b0;
      coin5_req_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      tmo_q        <= tmo_d;
      ack_sel_q    <= ack_sel_d;
      overflow_q   <= overflow_d;
      fault_q      <= fault_d;
      vend_req_q   <= vend_req_d;
      coin10_req_q <= coin10_req_d;
      coin5_req_q  <= coin5_req_d;
    end
  end

  assign bus.vend_req   = vend_req_q;
  assign bus.coin10_req = coin10_req_q;
  assign bus.coin5_req  = coin5_req_q;
  assign bus.busy       = (state_q != S_IDLE) || !fifo_empty;
  assign bus.fifo_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Randomized bench for vm_change_dispenser: an auto-acknowledging mechanism model records
// the order of request pulses and compares it against the expansion of every queued word.
module tb_vm_change_dispenser;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic clk;
  logic reset;
  vm_change_dispenser_if #(.FIFO_DEPTH(DEPTH)) bus ();

  vm_change_dispenser #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit auto_ack = 1'b0;
  int ack_dly = 0;

  // Event codes: 2 = product, 1 = 10tk coin, 0 = 5tk coin.
  int ev_q[$];
  int exp_q[$];
  int multi_cnt = 0;
  logic pv = 1'b0, p10 = 1'b0, p5 = 1'b0;

  always @(negedge clk) begin
    if (bus.vend_req === 1'b1 && !pv) ev_q.push_back(2);
    if (bus.coin10_req === 1'b1 && !p10) ev_q.push_back(1);
    if (bus.coin5_req === 1'b1 && !p5) ev_q.push_back(0);
    if ($countones({bus.vend_req === 1'b1, bus.coin10_req === 1'b1, bus.coin5_req === 1'b1}) > 1)
      multi_cnt++;
    pv  = (bus.vend_req === 1'b1);
    p10 = (bus.coin10_req === 1'b1);
    p5  = (bus.coin5_req === 1'b1);
  end

  initial begin
    bus.vend_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && bus.vend_req === 1'b1) begin
        repeat (ack_dly) @(negedge clk);
        bus.vend_ack = 1'b1;
        while (bus.vend_req === 1'b1) @(negedge clk);
        bus.vend_ack = 1'b0;
      end
    end
  end

  initial begin
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && (bus.coin5_req === 1'b1 || bus.coin10_req === 1'b1)) begin
        repeat (ack_dly) @(negedge clk);
        bus.coin_ack = 1'b1;
        while (bus.coin5_req === 1'b1 || bus.coin10_req === 1'b1) @(negedge clk);
        bus.coin_ack = 1'b0;
      end
    end
  end

  task automatic add_expected(input logic [2:0] w);
    if (w[2]) exp_q.push_back(2);
    if (w[1]) exp_q.push_back(1);
    if (w[0]) exp_q.push_back(0);
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0 && bus.vend_req === 1'b0 && bus.coin10_req === 1'b0 &&
          bus.coin5_req === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compare_events(input string name, input int base);
    int n;
    n = ev_q.size() - base;
    checks++;
    if (n != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d expected %0d", name, n, exp_q.size());
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (ev_q[base+i] != exp_q[i]) begin
          errors++;
          $display("FAIL %s event[%0d]: got %0d expected %0d", name, i, ev_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic drive_word(input logic [2:0] w);
    bus.purchase = w[2];
    bus.cash_ret = w[1:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.vend_req !== 1'b0) begin errors++; $display("FAIL reset vend_req: got %b expected 0", bus.vend_req); end
    checks++; if (bus.coin10_req !== 1'b0) begin errors++; $display("FAIL reset coin10_req: got %b expected 0", bus.coin10_req); end
    checks++; if (bus.coin5_req !== 1'b0) begin errors++; $display("FAIL reset coin5_req: got %b expected 0", bus.coin5_req); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL reset fifo_level: got %0d expected 0", bus.fifo_level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %b expected 0", bus.fault); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_change();
    int base;
    bit ok;
    base = ev_q.size();
    exp_q.delete();
    auto_ack = 1'b1;
    ack_dly = 3;
    drive_word(3'b111);
    add_expected(3'b111);
    @(negedge clk);
    drive_word(3'b000);
    checks++; if (bus.fifo_level !== 3'd1 || bus.vend_req !== 1'b0) begin errors++; $display("FAIL latency_edge0 level/vend_req: got %0d/%b expected 1/0", bus.fifo_level, bus.vend_req); end
    @(negedge clk);
    checks++; if (bus.fifo_level !== 3'd0 || bus.vend_req !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL latency_edge1 level/vend_req/busy: got %0d/%b/%b expected 0/0/1", bus.fifo_level, bus.vend_req, bus.busy); end
    @(negedge clk);
    checks++; if (bus.vend_req !== 1'b1) begin errors++; $display("FAIL latency_edge2 vend_req: got %b expected 1", bus.vend_req); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_change idle_timeout: got busy expected idle"); end
    compare_events("full_change", base);
  endtask

  task automatic test_coin5_only();
    int base;
    bit ok;
    base = ev_q.size();
    exp_q.delete();
    auto_ack = 1'b1;
    ack_dly = 1;
    drive_word(3'b001);
    add_expected(3'b001);
    @(negedge clk);
    drive_word(3'b000);
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coin5_only idle_timeout: got busy expected idle"); end
    compare_events("coin5_only", base);
  endtask

  task automatic test_random();
    int base, mbase, len;
    bit ok;
    logic [2:0] w;
    auto_ack = 1'b1;
    mbase = multi_cnt;
    for (int b = 0; b < 10; b++) begin
      base = ev_q.size();
      exp_q.delete();
      ack_dly = $urandom_range(0, 3);
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        w = 3'($urandom_range(0, 7));
        drive_word(w);
        add_expected(w);
        @(negedge clk);
      end
      drive_word(3'b000);
      wait_idle(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random burst%0d idle_timeout: got busy expected idle", b); end
      compare_events("random", base);
    end
    checks++; if (bus.overflow !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL random flags overflow/fault: got %b/%b expected 0/0", bus.overflow, bus.fault); end
    checks++; if (multi_cnt != mbase) begin errors++; $display("FAIL random one_req: got %0d overlaps expected 0", multi_cnt - mbase); end
  endtask

  task automatic test_overflow_timeout();
    int base;
    bit ok;
    logic [2:0] words [1:5];
    auto_ack = 1'b0;
    drive_word(3'b100);
    @(negedge clk);
    drive_word(3'b000);
    repeat (2) @(negedge clk);
    checks++; if (bus.vend_req !== 1'b1) begin errors++; $display("FAIL ovf vend_req_up: got %b expected 1", bus.vend_req); end
    for (int i = 1; i <= 5; i++) begin
      words[i] = 3'($urandom_range(1, 7));
      drive_word(words[i]);
      bus.clr_fault = (i == 5);
      @(negedge clk);
    end
    drive_word(3'b000);
    bus.clr_fault = 1'b0;
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL ovf level: got %0d expected 4", bus.fifo_level); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf overflow_set_wins: got %b expected 1", bus.overflow); end
    repeat (TMO - 6) @(negedge clk);
    checks++; if (bus.fault !== 1'b0 || bus.vend_req !== 1'b1) begin errors++; $display("FAIL tmo early fault/vend_req: got %b/%b expected 0/1", bus.fault, bus.vend_req); end
    @(negedge clk);
    checks++; if (bus.fault !== 1'b1 || bus.vend_req !== 1'b0) begin errors++; $display("FAIL tmo fault/vend_req: got %b/%b expected 1/0", bus.fault, bus.vend_req); end
    repeat (3) @(negedge clk);
    checks++; if (bus.fault !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL tmo sticky fault/busy: got %b/%b expected 1/1", bus.fault, bus.busy); end
    base = ev_q.size();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) add_expected(words[i]);
    auto_ack = 1'b1;
    ack_dly = 2;
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    checks++; if (bus.fault !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL clr fault/overflow: got %b/%b expected 0/0", bus.fault, bus.overflow); end
    wait_idle(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf drain idle_timeout: got busy expected idle"); end
    compare_events("ovf_drain", base);
  endtask

  task automatic test_reset_mid_coin10();
    bit seen;
    auto_ack = 1'b0;
    drive_word(3'b010);
    @(negedge clk);
    drive_word(3'b001);
    @(negedge clk);
    drive_word(3'b100);
    @(negedge clk);
    drive_word(3'b000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.coin10_req === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid coin10_req_up: got 0 expected 1"); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.coin10_req !== 1'b0) begin errors++; $display("FAIL rst_mid coin10_req: got %b expected 0", bus.coin10_req); end
    checks++; if (bus.fifo_level !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid level/busy: got %0d/%b expected 0/0", bus.fifo_level, bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    int base;
    base = ev_q.size();
    drive_word(3'b000);
    repeat (100) @(negedge clk);
    checks++; if (bus.fifo_level !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle level/busy: got %0d/%b expected 0/0", bus.fifo_level, bus.busy); end
    checks++; if (ev_q.size() != base) begin errors++; $display("FAIL idle req_count: got %0d expected 0", ev_q.size() - base); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.purchase = 1'b0;
    bus.cash_ret = 2'b00;
    bus.clr_fault = 1'b0;
    test_reset();
    test_full_change();
    test_coin5_only();
    test_random();
    test_overflow_timeout();
    test_reset_mid_coin10();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
